// File: rtl/rr_dest_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_dest_encoder_pkg
// Description : Shared constants for the register-bank destination path and
//               the index-to-one-hot helper used by both the encoder and the
//               bank write-enable decode.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_dest_encoder_pkg;

    // Width of a destination index and the number of registers it addresses.
    localparam int DEST_W   = 4;
    localparam int NUM_REGS = 1 << DEST_W;

    // One-hot write enable for a destination index.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [DEST_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_dest_encoder_prio_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_select
// Description : Combinational round-robin priority select. Finds the first
//               set bit of mask scanning upward from ptr, wrapping at the top.
//   mask  in   NUM_REGS  candidate request mask
//   ptr   in   DEST_W    index with highest priority this cycle
//   sel   out  DEST_W    selected index (meaningful only when found=1)
//   found out  1         mask has at least one set bit
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_select #(
    parameter int DEST_W   = 4,
    parameter int NUM_REGS = 1 << DEST_W
) (
    input  logic [NUM_REGS-1:0] mask,
    input  logic [DEST_W-1:0]   ptr,
    output logic [DEST_W-1:0]   sel,
    output logic                found
);

    logic [NUM_REGS-1:0] w_rot;
    logic [DEST_W-1:0]   w_off;
    logic [DEST_W-1:0]   w_idx;

    always_comb begin
        w_rot = '0;
        w_idx = '0;
        w_off = '0;
        found = 1'b0;

        // Rotate so that bit ptr lands at position 0; the DEST_W-bit add
        // wraps naturally, giving the 15 -> 0 scan order.
        for (int i = 0; i < NUM_REGS; i++) begin
            w_idx    = DEST_W'(i) + ptr;
            w_rot[i] = mask[w_idx];
        end

        // Lowest set bit of the rotated mask; scanning downward lets the
        // last assignment win.
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = DEST_W'(i);
            end
        end

        // Undo the rotation.
        sel = w_off + ptr;
    end

endmodule
`default_nettype wire

// File: rtl/rr_dest_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_dest_encoder
// Description : Round-robin encoder for register-bank write requests. Buffers
//               one-hot write requests as a sticky pending mask and issues one
//               destination index at a time over a valid/ready handshake.
//   clk        in   1         clock, rising edge
//   reset      in   1         synchronous active-high reset
//   req        in   NUM_REGS  write-request pulses, any number per cycle
//   dest       out  DEST_W    encoded destination index
//   dest_valid out  1         dest holds a pending request
//   dest_ready in   1         register bank accepts dest this cycle
//   grant      out  NUM_REGS  one-hot of dest while dest_valid, else zero
//   pending    out  NUM_REGS  sticky request mask, including the held entry
// Revision    : 1.0 - initial release
// ============================================================================
module rr_dest_encoder
    import rr_dest_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] req,
    output logic [DEST_W-1:0]   dest,
    output logic                dest_valid,
    input  logic                dest_ready,
    output logic [NUM_REGS-1:0] grant,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [DEST_W-1:0]   r_ptr;
    logic [DEST_W-1:0]   r_dest;
    logic                r_dest_valid;
    logic [NUM_REGS-1:0] r_grant;

    logic                w_fire;
    logic                w_load;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_cand;
    logic [DEST_W-1:0]   w_sel;
    logic                w_found;

    assign w_fire = r_dest_valid & dest_ready;
    // The output register may only advance when it is empty or being drained.
    assign w_load = ~r_dest_valid | w_fire;
    assign w_clr  = w_fire ? r_grant : '0;
    // Exclude the entry already held on dest so it is never issued twice.
    assign w_cand = r_pending & ~r_grant;

    rr_prio_select #(
        .DEST_W   (DEST_W),
        .NUM_REGS (NUM_REGS)
    ) u_prio_select (
        .mask  (w_cand),
        .ptr   (r_ptr),
        .sel   (w_sel),
        .found (w_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_ptr        <= '0;
            r_dest       <= '0;
            r_dest_valid <= 1'b0;
            r_grant      <= '0;
        end else begin
            // OR-ing req after the clear makes a same-cycle re-request win.
            r_pending <= (r_pending & ~w_clr) | req;
            if (w_load) begin
                if (w_found) begin
                    r_dest       <= w_sel;
                    r_dest_valid <= 1'b1;
                    r_grant      <= onehot(w_sel);
                    r_ptr        <= w_sel + DEST_W'(1);
                end else begin
                    r_dest_valid <= 1'b0;
                    r_grant      <= '0;
                end
            end
        end
    end

    assign dest       = r_dest;
    assign dest_valid = r_dest_valid;
    assign grant      = r_grant;
    assign pending    = r_pending;

endmodule
`default_nettype wire
